ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction fetch queue between the PC/fetch stage and decode, for the pipelined variant of the LEGv8 core. Takes fetch addresses from the PC stage, issues them to a variable-latency instruction memory, and collects in-order responses into a DEPTH-entry buffer. Presents {PC, instruction} pairs to decode with a valid/ready handshake. On a taken branch it flushes all buffered and in-flight fetches.

## Interface
Parameters:
- DEPTH, 4: buffer entries; power of two, ≥2
- AW, 64: address width
- IW, 32: instruction width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush_F  in  1  taken branch (driven from PCSrc_F); kill all queued and in-flight fetches
- fetch_valid_F  in  1  fetch address valid
- fetch_addr_F  in  AW  fetch address (imem_addr_F from PC stage)
- fetch_ready_F  out  1  address accepted this cycle; PC stage stalls when low
- imem_req  out  1  memory request
- imem_addr  out  AW  request address (= fetch_addr_F)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after grant
- imem_rdata  in  IW  response instruction
- instr_valid_D  out  1  head entry valid for decode
- instr_D  out  IW  head instruction
- pc_D  out  AW  head PC
- instr_ready_D  in  1  decode consumes head

## Operation
- State: head (pop), fill (next response slot), tail (next issue slot), each log2(DEPTH)+1 bits with wrap bit; discard counter, 0..DEPTH.
- Each entry holds pc, instr and a filled flag.
- Space available: tail−head < DEPTH.
- Issue: imem_req = fetch_valid_F & space & !flush_F. A handshake completes when imem_req & imem_gnt. It writes fetch_addr_F into entry[tail], clears filled and increments tail. fetch_ready_F = imem_req & imem_gnt.
- Response (imem_rvalid):
  - If discard>0: drop the response, discard−1.
  - Else: write imem_rdata to entry[fill], set filled, fill+1.
  - An rvalid with fill==tail and discard==0 is a protocol violation. It is ignored, with a simulation assertion.
- Pop: instr_valid_D = entry[head].filled & (head≠fill). Pop when instr_valid_D & instr_ready_D: head+1.
- Flush (highest priority): head, fill and tail all take tail's value; discard += (tail−fill) for the current cycle. No issue, pop or buffer write that cycle. A response arriving in the flush cycle counts toward the drop: discard = discard_old + (tail−fill) − rvalid_to_buffer. Fetching restarts the next cycle, with responses dropped until discard==0.
- Issue, response and pop may all occur in the same cycle; the pointers update independently.
- Full (tail−head==DEPTH): fetch_ready_F=0, PC holds. Empty: instr_valid_D=0.

## Timing
- Reset: pointers=0, discard=0, all filled=0. While reset is high: instr_valid_D=0, imem_req=0, fetch_ready_F=0. pc_D and instr_D are don't-care while instr_valid_D=0.
- Issue is combinational from fetch_valid_F/imem_gnt, with zero-cycle accept.
- Response to decode latency: entry visible the cycle after imem_rvalid (without bypass).
- Reset mid-operation: all entries and discard are cleared. Responses still returning after reset deasserts are a memory-side error; the memory is reset by the same signal.
- Throughput: one instruction per cycle sustained when memory grants every cycle and decode is always ready.

## Configuration
- IFQ_BYPASS_EN defined:
  - When head==fill (no filled entry waiting) and a response arrives with discard==0 and no flush, the response drives instr_valid_D/instr_D/pc_D combinationally in the same cycle.
  - If instr_ready_D is also high, head and fill both advance and the entry's filled flag stays clear.
  - Response-to-decode latency 0.
- Undefined: no combinational path from imem_rvalid/imem_rdata to the decode outputs; latency 1 cycle.

## Test plan
- Reset, then fetch 0x00,0x04,0x08 with 1-cycle memory and decode always ready:
  - No bypass: pc_D 0x00,0x04,0x08 on consecutive cycles, starting 2 cycles after the first grant.
  - IFQ_BYPASS_EN: starting 1 cycle after the first grant.
- Decode stalled (instr_ready_D=0), DEPTH=4 → after 4 grants fetch_ready_F=0. One pop → fetch_ready_F=1 in that same cycle.
- 3 requests in flight (0x10,0x14,0x18), flush_F=1 for one cycle, then fetch 0x40:
  - The three responses are dropped (discard 3→0).
  - The first instr_valid_D shows pc_D=0x40.
- Issue, response and pop in the same cycle at occupancy 2 → occupancy stays 2; order preserved, checked against a scoreboard.
- Random grant/rvalid latency 1–5 and random instr_ready_D over 1000 fetches with random flushes → decode stream equals the scoreboard model and no assertions fire.
- Assert reset mid-stream with 2 entries buffered → the next cycle instr_valid_D=0, imem_req=0, and occupancy is 0.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order instruction fetch buffer between the PC stage and decode.
// Issues fetch addresses to a variable-latency imem, gathers in-order responses
// into DEPTH slots and hands {pc, instr} pairs to decode over valid/ready.
// A taken branch (flush_F) kills buffered entries and counts in-flight
// responses so they are dropped when they come back.
// Optional macro IFQ_BYPASS_EN: a response landing on an empty head slot is
// presented to decode in the same cycle (zero response-to-decode latency).
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int IW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_F,
  input  logic          fetch_valid_F,
  input  logic [AW-1:0] fetch_addr_F,
  output logic          fetch_ready_F,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic          instr_valid_D,
  output logic [IW-1:0] instr_D,
  output logic [AW-1:0] pc_D,
  input  logic          instr_ready_D
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW   = IDXW + 1;
  // Back-to-back flushes can stack several windows of stale responses, so the
  // drop counter carries headroom beyond a single window of DEPTH.
  localparam int DW   = PW + 3;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  ent_t             ent_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    head_q, fill_q, tail_q;
  logic [PW-1:0]    occ, inflight;
  logic [DW-1:0]    discard_q;
  logic [IDXW-1:0]  head_idx, fill_idx, tail_idx;
  logic             rsp_any, rsp_wr, byp, head_vld, pop, space, issue;

  assign head_idx = head_q[IDXW-1:0];
  assign fill_idx = fill_q[IDXW-1:0];
  assign tail_idx = tail_q[IDXW-1:0];
  assign occ      = tail_q - head_q;
  assign inflight = tail_q - fill_q;

  // A response is legitimate if it is owed to the drop counter or matches an
  // outstanding request; only the latter lands in the buffer.
  assign rsp_any  = imem_rvalid & ((discard_q != '0) | (fill_q != tail_q));
  assign rsp_wr   = imem_rvalid & (discard_q == '0) & (fill_q != tail_q) & !flush_F;
  assign head_vld = filled_q[head_idx] & (head_q != fill_q);

`ifdef IFQ_BYPASS_EN
  // Head slot still waiting on its instruction: forward the response directly.
  assign byp     = rsp_wr & (head_q == fill_q);
  assign instr_D = byp ? imem_rdata : ent_q[head_idx].instr;
`else
  assign byp     = 1'b0;
  assign instr_D = ent_q[head_idx].instr;
`endif

  assign pc_D          = ent_q[head_idx].pc;
  assign instr_valid_D = !reset & (head_vld | byp);
  assign pop           = instr_valid_D & instr_ready_D & !flush_F;
  // A pop frees the head slot this cycle, so a full queue can still accept.
  assign space         = (occ < PW'(DEPTH)) | pop;
  assign imem_req      = !reset & fetch_valid_F & space & !flush_F;
  assign issue         = imem_req & imem_gnt;
  assign fetch_ready_F = issue;
  assign imem_addr     = fetch_addr_F;

  // Pointer, drop-counter and filled-flag update; flush overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      fill_q    <= '0;
      tail_q    <= '0;
      discard_q <= '0;
      filled_q  <= '0;
    end else if (flush_F) begin
      head_q    <= tail_q;
      fill_q    <= tail_q;
      discard_q <= discard_q + DW'(inflight) - DW'(rsp_any);
    end else begin
      if (imem_rvalid && discard_q != '0) discard_q <= discard_q - DW'(1);
      if (rsp_wr) begin
        fill_q <= fill_q + PW'(1);
        // A bypassed-and-consumed response never becomes a buffered entry.
        if (!(byp && pop)) filled_q[fill_idx] <= 1'b1;
      end
      if (issue) begin
        tail_q             <= tail_q + PW'(1);
        filled_q[tail_idx] <= 1'b0;
      end
      if (pop) head_q <= head_q + PW'(1);
    end
  end

  // Entry payload: pc captured at issue, instruction captured at response.
  always_ff @(posedge clk) begin
    if (rsp_wr && !reset) ent_q[fill_idx].instr <= imem_rdata;
    if (issue) ent_q[tail_idx].pc <= fetch_addr_F;
  end

  // A response with nothing outstanding and nothing to drop is a memory bug.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(imem_rvalid && !rsp_any));
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and randomized bench for ifetch_queue (default parameters).
module tb_ifetch_queue;
  logic        clk = 1'b0, reset = 1'b1, flush_F = 1'b0;
  logic        fetch_valid_F = 1'b0, fetch_ready_F, imem_req, imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0, instr_valid_D, instr_ready_D = 1'b0;
  logic [63:0] fetch_addr_F = '0, imem_addr, pc_D;
  logic [31:0] imem_rdata = '0, instr_D;
  int          n_chk = 0, n_pass = 0;

`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct { logic [31:0] d; int due; } mq_t;
  typedef struct { logic [63:0] pc; logic [31:0] d; } sb_t;

  ifetch_queue dut (
    .clk(clk), .reset(reset), .flush_F(flush_F), .fetch_valid_F(fetch_valid_F),
    .fetch_addr_F(fetch_addr_F), .fetch_ready_F(fetch_ready_F), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_valid_D(instr_valid_D), .instr_D(instr_D),
    .pc_D(pc_D), .instr_ready_D(instr_ready_D)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] dat(input logic [63:0] a);
    return 32'hD000_0000 ^ a[31:0];
  endfunction

  // One cycle of stimulus; returns 2 time units after the edge for sampling.
  task automatic drive(input logic rs, input logic fl, input logic fv, input logic [63:0] a,
                       input logic g, input logic rv, input logic [31:0] rd, input logic rdy);
    @(posedge clk); #1;
    reset = rs; flush_F = fl; fetch_valid_F = fv; fetch_addr_F = a;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; instr_ready_D = rdy;
    #1;
  endtask

  task automatic test_reset;
    repeat (2) drive(1, 0, 1, 64'h0, 1, 0, 0, 1);
    n_chk++; if (instr_valid_D !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid_D); else n_pass++;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
    n_chk++; if (fetch_ready_F !== 1'b0) $display("FAIL rst_ready: got %b want 0", fetch_ready_F); else n_pass++;
    drive(0, 0, 0, 64'h0, 0, 0, 0, 1);
    n_chk++; if (instr_valid_D !== 1'b0) $display("FAIL rst_empty: got %b want 0", instr_valid_D); else n_pass++;
  endtask

  task automatic test_basic;
    int n = 0, iss = 0, pc_c[3];
    logic [63:0] pcs[3], pa = '0;
    logic [31:0] ins[3];
    logic pg = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, iss < 3, 64'(iss * 4), 1, pg, dat(pa), 1);
      if (instr_valid_D && n < 3) begin pc_c[n] = c; pcs[n] = pc_D; ins[n] = instr_D; n++; end
      pg = fetch_ready_F;
      if (fetch_ready_F) begin pa = 64'(iss * 4); iss++; end
    end
    n_chk++; if (n !== 3) $display("FAIL basic_count: got %0d want 3", n); else n_pass++;
    for (int i = 0; i < 3 && i < n; i++) begin
      n_chk++; if (pc_c[i] !== LAT + i) $display("FAIL basic_cycle%0d: got %0d want %0d", i, pc_c[i], LAT + i); else n_pass++;
      n_chk++; if (pcs[i] !== 64'(4 * i) || ins[i] !== dat(64'(4 * i)))
        $display("FAIL basic_data%0d: got %h/%h want %h/%h", i, pcs[i], ins[i], 64'(4 * i), dat(64'(4 * i)));
      else n_pass++;
    end
  endtask

  task automatic test_full;
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 1, 64'h100 + 64'(4 * c), 1, c > 0, dat(64'h100 + 64'(4 * (c - 1))), 0);
      n_chk++; if (fetch_ready_F !== 1'b1) $display("FAIL full_fill%0d: got %b want 1", c, fetch_ready_F); else n_pass++;
    end
    drive(0, 0, 1, 64'h110, 1, 1, dat(64'h10C), 0);
    n_chk++; if (fetch_ready_F !== 1'b0) $display("FAIL full_stall: got %b want 0", fetch_ready_F); else n_pass++;
    drive(0, 0, 1, 64'h110, 1, 0, 0, 0);
    n_chk++; if (fetch_ready_F !== 1'b0 || instr_valid_D !== 1'b1 || pc_D !== 64'h100)
      $display("FAIL full_hold: got rdy %b vld %b pc %h want 0 1 100", fetch_ready_F, instr_valid_D, pc_D);
    else n_pass++;
    drive(0, 0, 1, 64'h110, 1, 0, 0, 1);
    n_chk++; if (fetch_ready_F !== 1'b1) $display("FAIL full_pop_accept: got %b want 1", fetch_ready_F); else n_pass++;
    n_chk++; if (pc_D !== 64'h100 || instr_D !== dat(64'h100))
      $display("FAIL full_pop_data: got %h/%h want 100/%h", pc_D, instr_D, dat(64'h100));
    else n_pass++;
    drive(0, 0, 0, 64'h0, 0, 1, dat(64'h110), 1);
    n_chk++; if (instr_valid_D !== 1'b1 || pc_D !== 64'h104) $display("FAIL full_drain0: got %b/%h want 1/104", instr_valid_D, pc_D); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 64'h0, 0, 0, 0, 1);
      n_chk++; if (instr_valid_D !== 1'b1 || pc_D !== 64'h108 + 64'(4 * k) || instr_D !== dat(64'h108 + 64'(4 * k)))
        $display("FAIL full_drain%0d: got %b/%h/%h want 1/%h", k + 1, instr_valid_D, pc_D, instr_D, 64'h108 + 64'(4 * k));
      else n_pass++;
    end
    drive(0, 0, 0, 64'h0, 0, 0, 0, 1);
    n_chk++; if (instr_valid_D !== 1'b0) $display("FAIL full_empty: got %b want 0", instr_valid_D); else n_pass++;
  endtask

  task automatic test_flush;
    int first = -1;
    logic [63:0] fpc = '0;
    logic [31:0] fins = '0;
    for (int c = 0; c < 3; c++) drive(0, 0, 1, 64'h10 + 64'(4 * c), 1, 0, 0, 1);
    drive(0, 1, 1, 64'h1C, 1, 0, 0, 1);
    n_chk++; if (imem_req !== 1'b0 || fetch_ready_F !== 1'b0)
      $display("FAIL flush_block: got req %b rdy %b want 0 0", imem_req, fetch_ready_F);
    else n_pass++;
    drive(0, 0, 1, 64'h40, 1, 1, dat(64'h10), 1);
    n_chk++; if (fetch_ready_F !== 1'b1 || instr_valid_D !== 1'b0)
      $display("FAIL flush_restart: got rdy %b vld %b want 1 0", fetch_ready_F, instr_valid_D);
    else n_pass++;
    drive(0, 0, 0, 64'h0, 0, 1, dat(64'h14), 1);
    n_chk++; if (instr_valid_D !== 1'b0) $display("FAIL flush_drop1: got %b want 0", instr_valid_D); else n_pass++;
    drive(0, 0, 0, 64'h0, 0, 1, dat(64'h18), 1);
    n_chk++; if (instr_valid_D !== 1'b0) $display("FAIL flush_drop2: got %b want 0", instr_valid_D); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 64'h0, 0, k == 0, dat(64'h40), 1);
      if (instr_valid_D && first < 0) begin first = k; fpc = pc_D; fins = instr_D; end
    end
    n_chk++; if (first !== LAT - 1) $display("FAIL flush_first_cycle: got %0d want %0d", first, LAT - 1); else n_pass++;
    n_chk++; if (fpc !== 64'h40 || fins !== dat(64'h40))
      $display("FAIL flush_first_pc: got %h/%h want 40/%h", fpc, fins, dat(64'h40));
    else n_pass++;
  endtask

  task automatic test_same_cycle;
    drive(0, 0, 1, 64'h200, 1, 0, 0, 0);
    drive(0, 0, 1, 64'h204, 1, 1, dat(64'h200), 0);
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, c < 3, 64'h208 + 64'(4 * c), 1, c < 4, dat(64'h204 + 64'(4 * c)), 1);
      n_chk++; if (fetch_ready_F !== (c < 3)) $display("FAIL same_issue%0d: got %b want %b", c, fetch_ready_F, c < 3); else n_pass++;
      n_chk++; if (instr_valid_D !== 1'b1 || pc_D !== 64'h200 + 64'(4 * c) || instr_D !== dat(64'h200 + 64'(4 * c)))
        $display("FAIL same_pop%0d: got %b/%h/%h want 1/%h", c, instr_valid_D, pc_D, instr_D, 64'h200 + 64'(4 * c));
      else n_pass++;
    end
    drive(0, 0, 0, 64'h0, 0, 0, 0, 1);
    n_chk++; if (instr_valid_D !== 1'b0) $display("FAIL same_empty: got %b want 0", instr_valid_D); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    drive(0, 0, 1, 64'h300, 1, 0, 0, 0);
    drive(0, 0, 1, 64'h304, 1, 1, dat(64'h300), 0);
    drive(0, 0, 0, 64'h0, 0, 1, dat(64'h304), 0);
    drive(1, 0, 1, 64'h308, 1, 0, 0, 0);
    n_chk++; if ({instr_valid_D, imem_req, fetch_ready_F} !== 3'b000)
      $display("FAIL midrst_during: got %b want 000", {instr_valid_D, imem_req, fetch_ready_F});
    else n_pass++;
    drive(0, 0, 0, 64'h0, 0, 0, 0, 0);
    n_chk++; if (instr_valid_D !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL midrst_after: got vld %b req %b want 0 0", instr_valid_D, imem_req);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 1, 64'h400 + 64'(4 * c), 1, c > 0, dat(64'h400 + 64'(4 * (c - 1))), 0);
      n_chk++; if (fetch_ready_F !== 1'b1) $display("FAIL midrst_fill%0d: got %b want 1", c, fetch_ready_F); else n_pass++;
    end
    drive(0, 0, 1, 64'h410, 1, 1, dat(64'h40C), 0);
    n_chk++; if (fetch_ready_F !== 1'b0) $display("FAIL midrst_full: got %b want 0", fetch_ready_F); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 64'h0, 0, 0, 0, 1);
      if (instr_valid_D) begin
        n_chk++; if (pc_D !== 64'h400 + 64'(4 * n)) $display("FAIL midrst_order%0d: got %h want %h", n, pc_D, 64'h400 + 64'(4 * n)); else n_pass++;
        n++;
      end
    end
    n_chk++; if (n !== 4) $display("FAIL midrst_count: got %0d want 4", n); else n_pass++;
  endtask

  task automatic test_random;
    mq_t mq[$];
    sb_t sb[$];
    sb_t e;
    int cyc = 0, issued = 0, last_due = 0, d;
    logic [31:0] seq = 32'h1;
    logic [63:0] pcm = 64'h1000;
    logic fl;
    while ((issued < 1000 || sb.size() > 0 || mq.size() > 0) && cyc < 20000) begin
      cyc++;
      fl = (issued < 1000) && ($urandom_range(0, 99) < 3);
      drive(0, fl, (issued < 1000) && ($urandom_range(0, 4) != 0), pcm, $urandom_range(0, 2) != 0,
            mq.size() > 0 && mq[0].due <= cyc, (mq.size() > 0) ? mq[0].d : 32'h0,
            (issued >= 1000) || ($urandom_range(0, 3) != 0));
      if (imem_rvalid) void'(mq.pop_front());
      if (instr_valid_D && instr_ready_D && !flush_F) begin
        n_chk++;
        if (sb.size() == 0) $display("FAIL random_pop cyc%0d: got pc %h, nothing expected", cyc, pc_D);
        else begin
          e = sb.pop_front();
          if (pc_D !== e.pc || instr_D !== e.d)
            $display("FAIL random_pop cyc%0d: got %h/%h want %h/%h", cyc, pc_D, instr_D, e.pc, e.d);
          else n_pass++;
        end
      end
      if (flush_F) begin
        sb.delete();
        pcm = 64'($urandom_range(0, 16383)) * 64'd4;
      end else if (fetch_ready_F) begin
        d = cyc + $urandom_range(1, 5);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{seq, d});
        sb.push_back('{fetch_addr_F, seq});
        seq++; issued++; pcm += 64'd4;
      end
    end
    n_chk++; if (cyc >= 20000 || sb.size() != 0)
      $display("FAIL random_drain: got cyc %0d left %0d want drained", cyc, sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full;
    test_flush;
    test_same_cycle;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
